// File: rtl/pwm_output_stage.sv
// pwm_output_stage
// Four free-running 8-bit PWM generators behind a shared power-of-two
// prescaler, feeding a registered eight-pin output mux. Duty and divider
// codes are shadowed and only change at a generator's period boundary,
// which keeps every period on the pins glitch-free.
module pwm_output_stage #(
    parameter int NUM_OUT = 8,
    parameter int PRE_W   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_OUT-1:0] reg_en_out,
    input  logic [NUM_OUT-1:0] reg_en_pwm_out,
    input  logic [7:0]         reg_out_3_0_pwm_chanel,
    input  logic [7:0]         reg_out_7_4_pwm_chanel,
    input  logic [7:0]         reg_pwm_gen_0_duty_cycle,
    input  logic [7:0]         reg_pwm_gen_1_duty_cycle,
    input  logic [7:0]         reg_pwm_gen_2_duty_cycle,
    input  logic [7:0]         reg_pwm_gen_3_duty_cycle,
    input  logic [7:0]         reg_pwm_gen_1_0_frequency_divider,
    input  logic [7:0]         reg_pwm_gen_3_2_frequency_divider,
    output logic [NUM_OUT-1:0] pwm_out,
    output logic [3:0]         period_end
);

    localparam int NUM_GEN = 4;

    // Per-generator views of the flat configuration bytes
    logic [7:0]           duty_in [NUM_GEN];
    logic [3:0]           div_in  [NUM_GEN];
    logic [2*NUM_OUT-1:0] sel_all;

    assign duty_in[0] = reg_pwm_gen_0_duty_cycle;
    assign duty_in[1] = reg_pwm_gen_1_duty_cycle;
    assign duty_in[2] = reg_pwm_gen_2_duty_cycle;
    assign duty_in[3] = reg_pwm_gen_3_duty_cycle;
    assign div_in[0]  = reg_pwm_gen_1_0_frequency_divider[3:0];
    assign div_in[1]  = reg_pwm_gen_1_0_frequency_divider[7:4];
    assign div_in[2]  = reg_pwm_gen_3_2_frequency_divider[3:0];
    assign div_in[3]  = reg_pwm_gen_3_2_frequency_divider[7:4];
    // Pin i's two-bit generator select sits at sel_all[2i+1:2i]
    assign sel_all    = {reg_out_7_4_pwm_chanel, reg_out_3_0_pwm_chanel};

    // State
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [7:0]         cnt_q     [NUM_GEN];
    logic [7:0]         cnt_d     [NUM_GEN];
    logic [7:0]         duty_sh_q [NUM_GEN];
    logic [7:0]         duty_sh_d [NUM_GEN];
    logic [3:0]         div_sh_q  [NUM_GEN];
    logic [3:0]         div_sh_d  [NUM_GEN];
    logic [NUM_GEN-1:0] pwm_q, pwm_d;
    logic [NUM_OUT-1:0] pin_q, pin_d;

    // Decode
    logic [PRE_W:0]     span [NUM_GEN];
    logic [PRE_W-1:0]   mask [NUM_GEN];
    logic [NUM_GEN-1:0] tick;
    logic [NUM_GEN-1:0] wrap;

    // Tick when the low div_sh bits of the prescaler are all ones; a zero
    // code gives an empty mask and therefore a tick every cycle
    always_comb begin
        for (int g = 0; g < NUM_GEN; g++) begin
            span[g] = {{PRE_W{1'b0}}, 1'b1} << div_sh_q[g];
            mask[g] = PRE_W'(span[g] - {{PRE_W{1'b0}}, 1'b1});
            tick[g] = ((pre_q & mask[g]) == mask[g]);
            wrap[g] = tick[g] && (cnt_q[g] == 8'hFF);
        end
    end

    // The last tick of a period is visible while it is happening
    assign period_end = wrap;

    // Next state for prescaler, counters, shadow registers and compare
    always_comb begin
        // NOTE: every target gets a default before any condition so no latch is inferred.
        pre_d = pre_q + PRE_W'(1);
        for (int g = 0; g < NUM_GEN; g++) begin
            cnt_d[g]     = cnt_q[g];
            duty_sh_d[g] = duty_sh_q[g];
            div_sh_d[g]  = div_sh_q[g];
            if (tick[g]) begin
                cnt_d[g] = cnt_q[g] + 8'd1;
            end
            // Shadows reload on the same edge the counter wraps to 0
            if (wrap[g]) begin
                duty_sh_d[g] = duty_in[g];
                div_sh_d[g]  = div_in[g];
            end
            pwm_d[g] = (duty_sh_q[g] == 8'hFF) | (cnt_q[g] < duty_sh_q[g]);
        end
    end

    // Pin mux: disabled pins are low, non-PWM pins are high, else follow a generator
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            pin_d[i] = reg_en_out[i] & (~reg_en_pwm_out[i] | pwm_q[sel_all[2*i +: 2]]);
        end
    end

    // Register all state; reset clears everything asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            pwm_q <= '0;
            pin_q <= '0;
            // NOTE: these arrays are small flop banks, not RAM, so each element is reset explicitly.
            for (int g = 0; g < NUM_GEN; g++) begin
                cnt_q[g]     <= '0;
                duty_sh_q[g] <= '0;
                div_sh_q[g]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pre_q <= pre_d;
            pwm_q <= pwm_d;
            pin_q <= pin_d;
            for (int g = 0; g < NUM_GEN; g++) begin
                cnt_q[g]     <= cnt_d[g];
                duty_sh_q[g] <= duty_sh_d[g];
                div_sh_q[g]  <= div_sh_d[g];
            end
        end
    end

    assign pwm_out = pin_q;

endmodule
